bus_tx_fifo_bank: RTL and testbench
===================================

Name: bus_tx_fifo_bank

Overview:
- Upstream feeder for bs_gnrtr_n_rbtr: one first-word-fall-through (FWFT) transmit FIFO per bus terminal.
- Host/agent side writes packets. Bus side exposes pndng/D_pop and accepts pop, with the same per-terminal semantics the bus arbiter expects.
- Adds per-terminal occupancy and sticky overflow/underflow flags for checker visibility.
- Packet format: bits [pckg_sz-1 -: 8] are the destination ID, and 8'hFF means broadcast. The bank does not inspect this field; packets pass through untouched.

Parameters:
- drvrs, 4, number of bus terminals (independent FIFOs), >=1
- pckg_sz, 16, packet width in bits, >=9
- depth, 8, entries per FIFO, >=2, need not be a power of 2
- cnt_w, $clog2(depth+1), occupancy width (derived, localparam)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- wr_en  in  drvrs  per-terminal write strobe from host
- wr_data  in  drvrs x pckg_sz  unpacked [drvrs-1:0] of [pckg_sz-1:0]; packet to enqueue
- full  out  drvrs  FIFO i holds depth entries
- count  out  drvrs x cnt_w  occupancy of FIFO i
- overflow  out  drvrs  sticky: write attempted while full with no pop
- underflow  out  drvrs  sticky: pop asserted while pndng=0
- pndng  out  drvrs  FIFO i non-empty (to bus pndng)
- pop  in  drvrs  bus consumes the head of FIFO i this cycle
- D_pop  out  drvrs x pckg_sz  unpacked [drvrs-1:0] of [pckg_sz-1:0]; head word of FIFO i (to bus D_pop)

Behaviour:
- Reset, asynchronous, any cycle:
  - wr_ptr, rd_ptr and count go to 0; full, pndng, overflow and underflow go to 0; D_pop reads all-zeros.
  - Storage contents need not be cleared.
  - Reset asserted mid-burst discards all queued packets. No pndng pulse occurs on deassertion.
- FWFT read side:
  - D_pop[i] = mem[i][rd_ptr] when count != 0, else all-zeros (combinational mux from storage).
  - pndng[i] = (count[i] != 0). full[i] = (count[i] == depth).
- Write latency: a write accepted at edge N is visible on pndng/D_pop/count immediately after edge N (1-cycle latency).
- Accepted write: wr_en & (!full | pop_valid). The word is stored at wr_ptr, and wr_ptr advances, wrapping depth-1 -> 0.
- Valid pop: pop & pndng. rd_ptr advances with the same wrap rule, and the next head appears after the edge.
- Count update per edge: +1 write only, -1 pop only, unchanged for both or neither.
- Simultaneous write and pop:
  - When full, both are accepted. Count stays at depth and full stays 1.
  - When count == 1, the head is consumed and the new word becomes the head after the edge. pndng stays 1.
  - When empty, the write is accepted, the pop is ignored and underflow is set.
- Write while full without pop: the word is dropped, pointers and count are unchanged, and overflow[i] is set.
- Pop while pndng=0: ignored and underflow[i] is set. Both sticky flags clear only on reset.
- FIFOs are fully independent; there is no cross-terminal interaction or arbitration in this block.
- No combinational path from wr_en/wr_data to pndng/D_pop. A combinational path exists from pop to write acceptance only.

Decomposition:
- Shared package (paquetes.sv) holds:
  - BCAST_ID = 8'hFF
  - function dest_id(pkt), returning pkt[pckg_sz-1 -: 8]
  - typedef fifo_err_e {FIFO_OK, FIFO_OVF, FIFO_UNF}, used by the scoreboard
- Sub-module bus_tx_fifo: one FWFT FIFO (params pckg_sz, depth), instantiated drvrs times in a generate loop. The top is only wiring.

Test Plan (drvrs=4, pckg_sz=16, depth=8):
1. Reset, then write 16'h02AB on terminal 1 at edge N -> after N: pndng=4'b0010, D_pop[1]=16'h02AB, count[1]=1. Pop at N+1 -> pndng=0, D_pop[1]=0.
2. Fill terminal 0 with 16'h0100..16'h0107 -> full[0]=1, count=8. A 9th write (16'h0108) -> dropped, overflow[0]=1. Eight pops return 0100..0107 in order, which also exercises the wrap.
3. Terminal 2 full: write 16'hFF55 and pop in the same cycle -> count stays 8, overflow[2]=0. The last of the next 8 pops returns 16'hFF55.
4. Terminal 3 empty: write 16'h0011 and pop in the same cycle -> count[3]=1, D_pop[3]=16'h0011, underflow[3]=1.
5. Terminal 0 holds 5 entries and terminal 1 holds 3. Assert reset asynchronously mid-cycle -> all outputs 0 immediately. After release, a fresh write 16'h0033 is the head and no stale data appears.
6. Random writes/pops on all 4 terminals for 2000 cycles against a queue model -> D_pop, pndng, count and flags match every cycle, and ordering is preserved per terminal.

Source files
------------

// File: rtl/paquetes.sv
// Shared definitions for the bus transmit path: broadcast ID, destination
// field helper and the error classification used when checking the FIFOs.
package paquetes;

  localparam logic [7:0] BCAST_ID = 8'hFF;
  localparam int PKT_MAX = 256;

  typedef enum logic [1:0] {
    FIFO_OK  = 2'd0,
    FIFO_OVF = 2'd1,
    FIFO_UNF = 2'd2
  } fifo_err_e;

  // Destination ID sits in the top byte of a packet of width sz.
  function automatic logic [7:0] dest_id(input logic [PKT_MAX-1:0] pkt, input int sz);
    return pkt[sz-1 -: 8];
  endfunction

endpackage

// File: rtl/bus_tx_fifo.sv
// One first-word-fall-through transmit FIFO for a single bus terminal, with
// occupancy and sticky overflow/underflow flags.
module bus_tx_fifo
  import paquetes::*;
#(
  parameter int pckg_sz = 16,
  parameter int depth   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [pckg_sz-1:0]           wr_data,
  input  logic                         pop,
  output logic                         full,
  output logic [$clog2(depth+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow,
  output logic                         pndng,
  output logic [pckg_sz-1:0]           d_pop
);

  localparam int CNT_W = $clog2(depth+1);
  localparam int PTR_W = $clog2(depth);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(depth-1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(depth);

  logic [pckg_sz-1:0] mem_q [depth];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               pop_valid;
  logic               wr_acc;

  assign pndng     = (count_q != '0);
  assign full      = (count_q == FULL_CNT);
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign d_pop     = pndng ? mem_q[rd_ptr_q] : '0;

  // A pop frees a slot in the same edge, so a full FIFO still takes a write.
  assign pop_valid = pop & pndng;
  assign wr_acc    = wr_en & (~full | pop_valid);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (wr_en & full & ~pop_valid);
    unf_d    = unf_q | (pop & ~pndng);
    if (wr_acc) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    if (pop_valid) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    case ({wr_acc, pop_valid})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is not reset; the read mux masks it whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/bus_tx_fifo_bank.sv
// Bank of independent FWFT transmit FIFOs, one per bus terminal, feeding the
// bus arbiter's pndng/D_pop/pop interface.
module bus_tx_fifo_bank
  import paquetes::*;
#(
  parameter int drvrs   = 4,
  parameter int pckg_sz = 16,
  parameter int depth   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [drvrs-1:0]             wr_en,
  input  logic [pckg_sz-1:0]           wr_data   [drvrs-1:0],
  output logic [drvrs-1:0]             full,
  output logic [$clog2(depth+1)-1:0]   count     [drvrs-1:0],
  output logic [drvrs-1:0]             overflow,
  output logic [drvrs-1:0]             underflow,
  output logic [drvrs-1:0]             pndng,
  input  logic [drvrs-1:0]             pop,
  output logic [pckg_sz-1:0]           D_pop     [drvrs-1:0]
);

  for (genvar g = 0; g < drvrs; g++) begin : g_fifo
    bus_tx_fifo #(
      .pckg_sz(pckg_sz),
      .depth  (depth)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en[g]),
      .wr_data  (wr_data[g]),
      .pop      (pop[g]),
      .full     (full[g]),
      .count    (count[g]),
      .overflow (overflow[g]),
      .underflow(underflow[g]),
      .pndng    (pndng[g]),
      .d_pop    (D_pop[g])
    );
  end

endmodule

// File: tb/tb_bus_tx_fifo_bank.sv
// Bench for bus_tx_fifo_bank: directed vector table, hand sequences for the
// full/empty/reset corners, then random traffic against per-terminal queues.
module tb_bus_tx_fifo_bank;
  import paquetes::*;

  localparam int DRVRS = 4;
  localparam int PSZ   = 16;
  localparam int DEPTH = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [DRVRS-1:0]  wr_en;
  logic [PSZ-1:0]    wr_data [DRVRS-1:0];
  logic [DRVRS-1:0]  full;
  logic [3:0]        count   [DRVRS-1:0];
  logic [DRVRS-1:0]  overflow;
  logic [DRVRS-1:0]  underflow;
  logic [DRVRS-1:0]  pndng;
  logic [DRVRS-1:0]  pop;
  logic [PSZ-1:0]    D_pop   [DRVRS-1:0];

  bus_tx_fifo_bank #(
    .drvrs  (DRVRS),
    .pckg_sz(PSZ),
    .depth  (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .underflow(underflow),
    .pndng    (pndng),
    .pop      (pop),
    .D_pop    (D_pop)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: one expected queue per terminal plus sticky flag model
  logic [PSZ-1:0]   exp_q [DRVRS][$];
  logic [DRVRS-1:0] ovf_m;
  logic [DRVRS-1:0] unf_m;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic reset_model();
    for (int t = 0; t < DRVRS; t++) exp_q[t].delete();
    ovf_m = '0;
    unf_m = '0;
  endtask

  // Apply the FIFO rules to the inputs that will be sampled at the next edge.
  task automatic model_edge();
    for (int t = 0; t < DRVRS; t++) begin
      fifo_err_e ev = FIFO_OK;
      bit pv  = pop[t] && (exp_q[t].size() != 0);
      bit acc = wr_en[t] && ((exp_q[t].size() < DEPTH) || pv);
      if (pop[t] && exp_q[t].size() == 0) ev = FIFO_UNF;
      if (wr_en[t] && !acc) ev = FIFO_OVF;
      if (pv) void'(exp_q[t].pop_front());
      if (acc) exp_q[t].push_back(wr_data[t]);
      if (ev == FIFO_OVF) ovf_m[t] = 1'b1;
      if (ev == FIFO_UNF) unf_m[t] = 1'b1;
    end
  endtask

  task automatic check_model(input string tag);
    for (int t = 0; t < DRVRS; t++) begin
      logic [PSZ-1:0] head;
      int sz;
      sz   = exp_q[t].size();
      head = (sz != 0) ? exp_q[t][0] : '0;
      check($sformatf("%s t%0d count", tag, t), 32'(count[t]), 32'(sz));
      check($sformatf("%s t%0d pndng", tag, t), 32'(pndng[t]), 32'(sz != 0));
      check($sformatf("%s t%0d full", tag, t), 32'(full[t]), 32'(sz == DEPTH));
      check($sformatf("%s t%0d D_pop", tag, t), 32'(D_pop[t]), 32'(head));
      check($sformatf("%s t%0d overflow", tag, t), 32'(overflow[t]), 32'(ovf_m[t]));
      check($sformatf("%s t%0d underflow", tag, t), 32'(underflow[t]), 32'(unf_m[t]));
    end
  endtask

  // driver tasks
  task automatic idle();
    wr_en = '0;
    pop   = '0;
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  typedef struct {
    logic [3:0]     wr_en;
    logic [3:0]     pop;
    logic [PSZ-1:0] data;
    int             term;
    logic [3:0]     exp_pndng;
    logic [3:0]     exp_cnt;
    logic [PSZ-1:0] exp_dpop;
    logic           exp_unf;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{4'b0010, 4'b0000, 16'h02AB, 1, 4'b0010, 4'd1, 16'h02AB, 1'b0};
    vecs[1] = '{4'b0000, 4'b0010, 16'h0000, 1, 4'b0000, 4'd0, 16'h0000, 1'b0};
    vecs[2] = '{4'b1000, 4'b1000, 16'h0011, 3, 4'b1000, 4'd1, 16'h0011, 1'b1};
    vecs[3] = '{4'b0000, 4'b1000, 16'h0000, 3, 4'b0000, 4'd0, 16'h0000, 1'b1};

    reset = 1'b1;
    idle();
    for (int t = 0; t < DRVRS; t++) wr_data[t] = '0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    check("reset pndng", 32'(pndng), 32'h0);
    reset = 1'b0;

    // directed vector table: single write/pop and simultaneous write+pop on empty
    for (int i = 0; i < 4; i++) begin
      wr_en = vecs[i].wr_en;
      pop   = vecs[i].pop;
      for (int t = 0; t < DRVRS; t++) wr_data[t] = vecs[i].data;
      step($sformatf("vec%0d", i));
      check($sformatf("vec%0d pndng", i), 32'(pndng), 32'(vecs[i].exp_pndng));
      check($sformatf("vec%0d count", i), 32'(count[vecs[i].term]), 32'(vecs[i].exp_cnt));
      check($sformatf("vec%0d D_pop", i), 32'(D_pop[vecs[i].term]), 32'(vecs[i].exp_dpop));
      check($sformatf("vec%0d underflow", i), 32'(underflow[vecs[i].term]), 32'(vecs[i].exp_unf));
    end
    idle();

    // fill terminal 0, overflow it, drain in order across the wrap
    wr_en = 4'b0001;
    for (int i = 0; i < DEPTH; i++) begin
      wr_data[0] = 16'(32'h0100 + i);
      step("fill0");
    end
    check("fill0 full", 32'(full[0]), 32'h1);
    check("fill0 count", 32'(count[0]), 32'h8);
    wr_data[0] = 16'h0108;
    step("ovf0");
    check("ovf0 overflow", 32'(overflow[0]), 32'h1);
    check("ovf0 count", 32'(count[0]), 32'h8);
    wr_en = '0;
    pop   = 4'b0001;
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain0 %0d", i), 32'(D_pop[0]), 32'h0100 + 32'(i));
      step("drain0");
    end
    idle();
    check("drain0 pndng", 32'(pndng[0]), 32'h0);

    // terminal 2 full: write and pop together keep it full without overflow
    wr_en = 4'b0100;
    for (int i = 0; i < DEPTH; i++) begin
      wr_data[2] = 16'(32'h2200 + i);
      step("fill2");
    end
    wr_data[2] = 16'hFF55;
    pop = 4'b0100;
    step("wp2");
    check("wp2 count", 32'(count[2]), 32'h8);
    check("wp2 full", 32'(full[2]), 32'h1);
    check("wp2 overflow", 32'(overflow[2]), 32'h0);
    wr_en = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) check("drain2 last", 32'(D_pop[2]), 32'hFF55);
      step("drain2");
    end
    idle();

    // asynchronous reset mid-cycle with data queued on terminals 0 and 1
    for (int i = 0; i < 5; i++) begin
      wr_en = (i < 3) ? 4'b0011 : 4'b0001;
      wr_data[0] = 16'(32'h0500 + i);
      wr_data[1] = 16'(32'h0600 + i);
      step("pre_rst");
    end
    idle();
    #3 reset = 1'b1;
    #1;
    check("arst pndng", 32'(pndng), 32'h0);
    check("arst count0", 32'(count[0]), 32'h0);
    check("arst count1", 32'(count[1]), 32'h0);
    check("arst D_pop0", 32'(D_pop[0]), 32'h0);
    check("arst D_pop1", 32'(D_pop[1]), 32'h0);
    check("arst overflow", 32'(overflow), 32'h0);
    check("arst underflow", 32'(underflow), 32'h0);
    reset_model();
    @(posedge clk);
    #1;
    check_model("in_rst");
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst pndng", 32'(pndng), 32'h0);
    check_model("post_rst");
    wr_en = 4'b0001;
    wr_data[0] = 16'h0033;
    step("fresh");
    check("fresh D_pop0", 32'(D_pop[0]), 32'h0033);
    check("fresh count0", 32'(count[0]), 32'h1);
    check("fresh pndng", 32'(pndng), 32'h1);
    idle();

    // random traffic, alternating fill-biased and drain-biased phases
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int wb;
      wb = ((cyc / 250) % 2 == 0) ? 70 : 30;
      for (int t = 0; t < DRVRS; t++) begin
        logic [PSZ-1:0] d;
        d = PSZ'($urandom);
        if ($urandom_range(0, 7) == 0) d[PSZ-1 -: 8] = BCAST_ID;
        wr_data[t] = d;
        wr_en[t] = ($urandom_range(0, 99) < wb);
        pop[t]   = ($urandom_range(0, 99) < (100 - wb));
      end
      step("rand");
    end
    idle();
    step("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
